// File: rtl/addr_decoder_multi_pkg.sv
// Shared types and defaults for the serial address decoder: FSM states, the
// default three-target map, and helpers for select-index width and one-hot decode.
package addr_decoder_pkg;

    typedef enum logic [1:0] {
        ST_ADDR    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_NUM_TARGETS = 3;
    localparam logic [DEF_NUM_TARGETS*DEF_ADDR_W-1:0] DEF_TGT_BASE = {16'h8000, 16'h4000, 16'h0000};
    localparam logic [DEF_NUM_TARGETS*DEF_ADDR_W-1:0] DEF_TGT_MASK = {16'hF000, 16'hC000, 16'hF800};

    localparam int MAX_TARGETS = 32;

    function automatic int sel_width(input int num_targets);
        return (num_targets > 1) ? $clog2(num_targets) : 1;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_TARGETS-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_TARGETS; i++) begin
            if (onehot[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/addr_decoder_multi_if.sv
// Serial bus inputs and target-select outputs of the address decoder.
// The master side drives the serial bus; the decoder uses the slave modport.
interface addr_decoder_multi_if #(
    parameter int NUM_TARGETS = 3,
    parameter int SEL_W       = addr_decoder_pkg::sel_width(NUM_TARGETS)
);
    logic                   bus_data_in;
    logic                   bus_data_in_valid;
    logic                   bus_mode;
    logic [NUM_TARGETS-1:0] tgt_valid;
    logic [SEL_W-1:0]       sel;
    logic                   decode_err;
    logic                   busy;

    modport master (
        output bus_data_in, bus_data_in_valid, bus_mode,
        input  tgt_valid, sel, decode_err, busy
    );

    modport slave (
        input  bus_data_in, bus_data_in_valid, bus_mode,
        output tgt_valid, sel, decode_err, busy
    );
endinterface

// File: rtl/addr_decoder_multi_match.sv
// Combinational base/mask address compare against the target table; the
// lowest-index hit wins when windows overlap.
module addr_map_match
    import addr_decoder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_TARGETS = DEF_NUM_TARGETS,
    parameter int SEL_W       = sel_width(NUM_TARGETS),
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  idx
);
    logic [NUM_TARGETS-1:0] hit_vec;
    logic [NUM_TARGETS-1:0] win_onehot;
    logic [MAX_TARGETS-1:0] win_ext;

    generate
        for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_cmp
            assign hit_vec[gi] = ((addr ^ TGT_BASE[gi*ADDR_W +: ADDR_W])
                                  & TGT_MASK[gi*ADDR_W +: ADDR_W]) == '0;
        end
    endgenerate

    // Two's-complement trick isolates the lowest set bit.
    assign win_onehot = hit_vec & (~hit_vec + NUM_TARGETS'(1));
    assign win_ext    = MAX_TARGETS'(win_onehot);
    assign hit        = |hit_vec;
    assign idx        = SEL_W'(onehot_to_idx(win_ext));
endmodule

// File: rtl/addr_decoder_multi.sv
// Serial-bus address decoder: shifts in an LSB-first address, matches it against
// the target map, and holds one target select for a fixed-length data phase.
module addr_decoder_multi
    import addr_decoder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_TARGETS = DEF_NUM_TARGETS,
    parameter int DATA_BITS   = 8,
    parameter int BURST_WORDS = 1,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK
) (
    input  logic               clk,
    input  logic               rst_n,
    addr_decoder_multi_if.slave bus
);
    localparam int SEL_W      = sel_width(NUM_TARGETS);
    localparam int TOTAL_BITS = DATA_BITS * BURST_WORDS;
    localparam int ACNT_W     = $clog2(ADDR_W);
    localparam int DCNT_W     = $clog2(TOTAL_BITS + 1);

    state_t                 state_reg, state_next;
    logic [ADDR_W-2:0]      shift_reg, shift_next;
    logic [ACNT_W-1:0]      addr_cnt_reg, addr_cnt_next;
    logic [DCNT_W-1:0]      data_cnt_reg, data_cnt_next;
    logic                   hit_reg, hit_next;
    logic [SEL_W-1:0]       win_reg, win_next;
    logic [NUM_TARGETS-1:0] tgt_valid_reg, tgt_valid_next;
    logic [SEL_W-1:0]       sel_reg, sel_next;
    logic                   decode_err_reg, decode_err_next;

    logic [ADDR_W-1:0] addr_full;
    logic              match_hit;
    logic [SEL_W-1:0]  match_idx;
    logic              addr_bit;
    logic              data_bit;

    // The newest bit arrives live, so only ADDR_W-1 earlier bits need storing.
    assign addr_full = {bus.bus_data_in, shift_reg};
    assign addr_bit  = bus.bus_data_in_valid & ~bus.bus_mode;
    assign data_bit  = bus.bus_data_in_valid &  bus.bus_mode;

    addr_map_match #(
        .ADDR_W      (ADDR_W),
        .NUM_TARGETS (NUM_TARGETS),
        .SEL_W       (SEL_W),
        .TGT_BASE    (TGT_BASE),
        .TGT_MASK    (TGT_MASK)
    ) u_match (
        .addr (addr_full),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_ADDR;
            shift_reg      <= '0;
            addr_cnt_reg   <= '0;
            data_cnt_reg   <= '0;
            hit_reg        <= 1'b0;
            win_reg        <= '0;
            tgt_valid_reg  <= '0;
            sel_reg        <= '0;
            decode_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            addr_cnt_reg   <= addr_cnt_next;
            data_cnt_reg   <= data_cnt_next;
            hit_reg        <= hit_next;
            win_reg        <= win_next;
            tgt_valid_reg  <= tgt_valid_next;
            sel_reg        <= sel_next;
            decode_err_reg <= decode_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        addr_cnt_next   = addr_cnt_reg;
        data_cnt_next   = data_cnt_reg;
        hit_next        = hit_reg;
        win_next        = win_reg;
        tgt_valid_next  = tgt_valid_reg;
        sel_next        = sel_reg;
        decode_err_next = 1'b0;

        case (state_reg)
            ST_ADDR: begin
                if (addr_bit) begin
                    shift_next = addr_full[ADDR_W-1:1];
                    if (addr_cnt_reg == ACNT_W'(ADDR_W - 1)) begin
                        addr_cnt_next = '0;
                        hit_next      = match_hit;
                        win_next      = match_idx;
                        state_next    = ST_DECODE;
                    end else begin
                        addr_cnt_next = addr_cnt_reg + ACNT_W'(1);
                    end
                end
            end
            ST_DECODE: begin
                if (hit_reg) begin
                    tgt_valid_next = NUM_TARGETS'(1) << win_reg;
                    sel_next       = win_reg;
                    state_next     = ST_HOLD;
                end else begin
                    decode_err_next = 1'b1;
                    state_next      = ST_ADDR;
                end
            end
            ST_HOLD: begin
                if (addr_bit) begin
                    // A new address bit aborts the data phase and starts the next address.
                    tgt_valid_next = '0;
                    sel_next       = '0;
                    data_cnt_next  = '0;
                    shift_next     = addr_full[ADDR_W-1:1];
                    addr_cnt_next  = ACNT_W'(1);
                    state_next     = ST_ADDR;
                end else if (data_bit) begin
                    if (data_cnt_reg == DCNT_W'(TOTAL_BITS - 1)) begin
                        data_cnt_next = '0;
                        state_next    = ST_RELEASE;
                    end else begin
                        data_cnt_next = data_cnt_reg + DCNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                tgt_valid_next = '0;
                sel_next       = '0;
                state_next     = ST_ADDR;
            end
            default: state_next = ST_ADDR;
        endcase
    end

    assign bus.tgt_valid  = tgt_valid_reg;
    assign bus.sel        = sel_reg;
    assign bus.decode_err = decode_err_reg;
    assign bus.busy       = (state_reg != ST_ADDR);
endmodule
